// File: rtl/rot_addr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rot_addr_ctrl
// Brief    : Multi-channel address stepper driven by a debounced rotary encoder
// Revision : 1.0 - initial release
// ============================================================================
module rot_addr_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int ADDR_W     = 5,
    parameter int MAX_ADDR   = 31,
    parameter int STEP       = 1,
    parameter int FAST_SHIFT = 2,
    parameter int WRAP       = 1,
    parameter int LOCKOUT    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rot_a,
    input  logic                     rot_b,
    input  logic [CH_W-1:0]          ch_sel,
    input  logic                     fast,
    input  logic                     clr,
    output logic [ADDR_W-1:0]        addr_sel,
    output logic [NUM_CH*ADDR_W-1:0] addr_all,
    output logic                     evt_inc,
    output logic                     evt_dec,
    output logic                     evt_lim
);

    localparam logic [ADDR_W:0] c_max       = (ADDR_W+1)'(MAX_ADDR);
    localparam logic [ADDR_W:0] c_mod       = (ADDR_W+1)'(MAX_ADDR + 1);
    localparam logic [ADDR_W:0] c_step_norm = (ADDR_W+1)'(STEP);
    localparam logic [ADDR_W:0] c_step_fast = (ADDR_W+1)'(STEP << FAST_SHIFT);
    localparam logic [CH_W:0]   c_num_ch    = (CH_W+1)'(NUM_CH);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOCK = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_a_q;
    logic              r_b_q;
    logic [ADDR_W-1:0] r_addr [NUM_CH];

    logic              w_dec_req;
    logic              w_inc_req;
    logic              w_accept;
    logic              w_ch_ok;
    logic              w_wr;
    logic [ADDR_W:0]   w_cur;
    logic [ADDR_W:0]   w_step;
    logic [ADDR_W:0]   w_sum;
    logic [ADDR_W-1:0] w_next;
    logic [ADDR_W-1:0] w_wdata;
    logic              w_lim;

    assign w_dec_req = rot_a & ~r_a_q & ~rot_b;
    assign w_inc_req = rot_b & ~r_b_q & ~rot_a;
    assign w_accept  = (w_inc_req | w_dec_req) & ((LOCKOUT == 0) | (r_state == S_IDLE));
    assign w_ch_ok   = ({1'b0, ch_sel} < c_num_ch);
    assign w_wr      = w_ch_ok & (clr | w_accept);
    assign w_wdata   = clr ? '0 : w_next;

    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == CH_W'(i)) addr_sel = r_addr[i];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign addr_all[g*ADDR_W +: ADDR_W] = r_addr[g];
    end

    // Arithmetic is one bit wider than the register so sums and wrap terms never overflow.
    assign w_cur  = {1'b0, addr_sel};
    assign w_step = fast ? c_step_fast : c_step_norm;
    assign w_sum  = w_cur + w_step;

    always_comb begin
        w_next = addr_sel;
        w_lim  = 1'b0;
        if (w_inc_req) begin
            if (w_sum > c_max) begin
                w_lim  = 1'b1;
                w_next = (WRAP != 0) ? ADDR_W'(w_sum - c_mod) : ADDR_W'(c_max);
            end else begin
                w_next = ADDR_W'(w_sum);
            end
        end else if (w_dec_req) begin
            if (w_cur >= w_step) begin
                w_next = ADDR_W'(w_cur - w_step);
            end else begin
                w_lim  = 1'b1;
                w_next = (WRAP != 0) ? ADDR_W'(w_cur + c_mod - w_step) : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Capture current levels so an input already high at release is not an edge.
            r_a_q   <= rot_a;
            r_b_q   <= rot_b;
            r_state <= S_IDLE;
            evt_inc <= 1'b0;
            evt_dec <= 1'b0;
            evt_lim <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) r_addr[i] <= '0;
        end else begin
            r_a_q <= rot_a;
            r_b_q <= rot_b;

            case (r_state)
                S_IDLE:  if (w_inc_req | w_dec_req) r_state <= S_LOCK;
                S_LOCK:  if (!rot_a && !rot_b)      r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            evt_inc <= w_accept & w_ch_ok & ~clr & w_inc_req;
            evt_dec <= w_accept & w_ch_ok & ~clr & w_dec_req;
            evt_lim <= w_accept & w_ch_ok & ~clr & w_lim;

            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr && ch_sel == CH_W'(i)) r_addr[i] <= w_wdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rot_addr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rot_addr_ctrl
// Brief    : Self-checking bench: wrap/4-channel and saturate/3-channel instances
// Revision : 1.0 - initial release
// ============================================================================
module tb_rot_addr_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rot_a = 1'b0;
    logic        rot_b = 1'b0;
    logic [1:0]  ch_sel = 2'd0;
    logic        fast = 1'b0;
    logic        clr = 1'b0;

    logic [4:0]  sel1, sel2;
    logic [19:0] all1;
    logic [14:0] all2;
    logic        inc1, dec1, lim1, inc2, dec2, lim2;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: [0] = wrap, 4 channels; [1] = saturate, 3 channels.
    int m_addr [2][4];
    int m_num  [2] = '{4, 3};
    bit m_wrap [2] = '{1'b1, 1'b0};
    bit e_inc  [2];
    bit e_dec  [2];
    bit e_lim  [2];
    bit m_locked;
    bit m_pa, m_pb;

    always #5 clk = ~clk;

    rot_addr_ctrl #(.NUM_CH(4), .WRAP(1)) dut1 (
        .clk(clk), .rst(rst), .rot_a(rot_a), .rot_b(rot_b), .ch_sel(ch_sel),
        .fast(fast), .clr(clr), .addr_sel(sel1), .addr_all(all1),
        .evt_inc(inc1), .evt_dec(dec1), .evt_lim(lim1));

    rot_addr_ctrl #(.NUM_CH(3), .WRAP(0)) dut2 (
        .clk(clk), .rst(rst), .rot_a(rot_a), .rot_b(rot_b), .ch_sel(ch_sel),
        .fast(fast), .clr(clr), .addr_sel(sel2), .addr_all(all2),
        .evt_inc(inc2), .evt_dec(dec2), .evt_lim(lim2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Detent semantics from the encoder rules, applied to the pre-edge inputs.
    task automatic model_edge();
        bit inc, dec, acc;
        int st, s;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 4; i++) m_addr[k][i] = 0;
                e_inc[k] = 0; e_dec[k] = 0; e_lim[k] = 0;
            end
            m_locked = 0;
        end else begin
            dec = rot_a && !m_pa && !rot_b;
            inc = rot_b && !m_pb && !rot_a;
            acc = (inc || dec) && !m_locked;
            if (!m_locked) m_locked = inc || dec;
            else if (!rot_a && !rot_b) m_locked = 0;
            st = fast ? 4 : 1;
            for (int k = 0; k < 2; k++) begin
                e_inc[k] = 0; e_dec[k] = 0; e_lim[k] = 0;
                if (int'(ch_sel) < m_num[k]) begin
                    if (clr) m_addr[k][ch_sel] = 0;
                    else if (acc) begin
                        s = m_addr[k][ch_sel];
                        e_inc[k] = inc;
                        e_dec[k] = dec;
                        if (inc) begin
                            s = s + st;
                            if (s > 31) begin
                                e_lim[k] = 1;
                                s = m_wrap[k] ? s - 32 : 31;
                            end
                        end else if (s >= st) s = s - st;
                        else begin
                            e_lim[k] = 1;
                            s = m_wrap[k] ? s + 32 - st : 0;
                        end
                        m_addr[k][ch_sel] = s;
                    end
                end
            end
        end
        m_pa = rot_a;
        m_pb = rot_b;
    endtask

    task automatic tick();
        logic [19:0] x1;
        logic [14:0] x2;
        logic [4:0]  s1, s2;
        @(posedge clk);
        model_edge();
        #1;
        x1 = '0;
        x2 = '0;
        for (int i = 0; i < 4; i++) x1[i*5 +: 5] = 5'(m_addr[0][i]);
        for (int i = 0; i < 3; i++) x2[i*5 +: 5] = 5'(m_addr[1][i]);
        s1 = 5'(m_addr[0][ch_sel]);
        s2 = (int'(ch_sel) < 3) ? 5'(m_addr[1][ch_sel]) : 5'd0;
        chk("wrap_all", 32'(all1), 32'(x1));
        chk("wrap_sel", 32'(sel1), 32'(s1));
        chk("wrap_evt", {29'd0, inc1, dec1, lim1}, {29'd0, e_inc[0], e_dec[0], e_lim[0]});
        chk("sat_all",  32'(all2), 32'(x2));
        chk("sat_sel",  32'(sel2), 32'(s2));
        chk("sat_evt",  {29'd0, inc2, dec2, lim2}, {29'd0, e_inc[1], e_dec[1], e_lim[1]});
    endtask

    task automatic detent(input bit use_b);
        if (use_b) rot_b = 1'b1; else rot_a = 1'b1;
        tick();
        rot_a = 1'b0; rot_b = 1'b0;
        tick();
    endtask

    initial begin
        int n_inc;
        int r;

        // Reset
        rst = 1'b1; tick(); tick();
        rst = 1'b0; tick();
        chk("reset_all", 32'(all1), 32'd0);

        // Three B detents on channel 0
        ch_sel = 2'd0;
        n_inc = 0;
        for (int i = 0; i < 3; i++) begin
            rot_b = 1'b1; tick(); n_inc += int'(inc1);
            rot_b = 1'b0; tick(); n_inc += int'(inc1);
        end
        chk("inc_count", 32'(n_inc), 32'd3);
        chk("ch0_is_3", 32'(sel1), 32'd3);

        // A detent on channel 1 from 0: wrap to 31 / saturate at 0
        ch_sel = 2'd1;
        detent(1'b0);
        chk("ch1_wrap31", 32'(sel1), 32'd31);

        // Channel 2: reach 28 fast, then 30, then fast B past the top
        ch_sel = 2'd2;
        fast = 1'b1;
        for (int i = 0; i < 7; i++) detent(1'b1);
        fast = 1'b0;
        detent(1'b1); detent(1'b1);
        fast = 1'b1;
        rot_b = 1'b1; tick();
        chk("sat_clamp31", {30'd0, inc2, lim2}, 32'd3);
        rot_b = 1'b0; tick();
        chk("sat_val31", 32'(sel2), 32'd31);
        fast = 1'b0;

        // Lockout: A toggles while B high -> a single increment
        ch_sel = 2'd0;
        rot_b = 1'b1; tick();
        rot_a = 1'b1; tick();
        rot_a = 1'b0; tick();
        rot_b = 1'b0; tick();
        chk("lock_one_inc", 32'(sel1), 32'd4);
        detent(1'b1);

        // clr on the same edge as an accepted B rise, then still locked
        ch_sel = 2'd2;
        clr = 1'b1; rot_b = 1'b1; tick();
        clr = 1'b0;
        rot_b = 1'b0; rot_a = 1'b1; tick();
        rot_a = 1'b0; tick();
        detent(1'b1);

        // Out-of-range channel on the 3-channel instance
        ch_sel = 2'd3;
        detent(1'b1);
        clr = 1'b1; tick(); clr = 1'b0;

        // rot_a high across reset release
        rot_a = 1'b1; rst = 1'b1; tick();
        rst = 1'b0; tick(); tick();
        chk("rel_no_dec", 32'(all1), 32'd0);
        rot_a = 1'b0; tick();

        // Reset while locked
        ch_sel = 2'd1;
        rot_b = 1'b1; tick();
        rst = 1'b1; tick();
        rst = 1'b0; rot_b = 1'b0; tick();
        detent(1'b1);

        // Randomised encoder traffic
        for (int c = 0; c < 600; c++) begin
            r = int'($urandom_range(0, 9));
            if (r >= 6) {rot_a, rot_b} = 2'($urandom_range(0, 3));
            fast = 1'($urandom_range(0, 1));
            clr  = ($urandom_range(0, 24) == 0);
            rst  = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 7) == 0) ch_sel = 2'($urandom_range(0, 3));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
